// File: rtl/imm_encode.sv
// imm_encode: packs an immediate plus register/opcode fields into an RV32I
// instruction word (I/S/B/J/U) and expands li requests into LUI+ADDI.
// Ports: clk_i/rst_i (async active-high), in_valid_i/in_ready_o request
// handshake, li_i, imm_src_i, opcode_i, funct3_i, rd_i, rs1_i, rs2_i,
// imm_i request fields; out_valid_o/out_ready_i beat handshake, instr_o,
// err_o (range/alignment/encoding error), last_o (final beat of request).
module imm_encode #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  li_i,
  input  logic [2:0]            imm_src_i,
  input  logic [6:0]            opcode_i,
  input  logic [2:0]            funct3_i,
  input  logic [4:0]            rd_i,
  input  logic [4:0]            rs1_i,
  input  logic [4:0]            rs2_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic                  err_o,
  output logic                  last_o
);

  typedef enum logic [0:0] {
    S_IDLE,
    S_SECOND
  } state_t;

  state_t                state;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] instr;
  logic                  err;
  logic                  last;
  logic [DATA_WIDTH-1:0] pend;

  // Signed-range checks: the bits above the field must all equal its sign.
  logic fits12;
  logic fits13;
  logic fits21;

  assign fits12 = (imm_i[31:11] == '0) || (imm_i[31:11] == '1);
  assign fits13 = (imm_i[31:12] == '0) || (imm_i[31:12] == '1);
  assign fits21 = (imm_i[31:20] == '0) || (imm_i[31:20] == '1);

  // ADDI sign-extends lo, so hi is pre-incremented when lo is negative.
  logic [11:0] li_lo;
  logic [19:0] li_hi;
  logic [31:0] lui_w;
  logic [31:0] addi_rd_w;
  logic [31:0] addi_x0_w;

  assign li_lo     = imm_i[11:0];
  assign li_hi     = imm_i[31:12] + {19'd0, imm_i[11]};
  assign lui_w     = {li_hi, rd_i, 7'b0110111};
  assign addi_rd_w = {li_lo, rd_i, 3'b000, rd_i, 7'b0010011};
  assign addi_x0_w = {li_lo, 5'd0, 3'b000, rd_i, 7'b0010011};

  logic [31:0] enc_instr;
  logic        enc_err;
  logic        enc_two;
  logic [31:0] enc_pend;

  always_comb begin
    enc_instr = '0;
    enc_err   = 1'b0;
    enc_two   = 1'b0;
    enc_pend  = '0;
    if (li_i) begin
      if (li_hi == '0) begin
        enc_instr = addi_x0_w;
      end else if (li_lo == '0) begin
        enc_instr = lui_w;
      end else begin
        enc_instr = lui_w;
        enc_two   = 1'b1;
        enc_pend  = addi_rd_w;
      end
    end else begin
      case (imm_src_i)
        3'b000: begin
          enc_instr = {imm_i[11:0], rs1_i, funct3_i,
                       rd_i, opcode_i};
          enc_err   = !fits12;
        end
        3'b001: begin
          enc_instr = {imm_i[11:5], rs2_i, rs1_i,
                       funct3_i, imm_i[4:0], opcode_i};
          enc_err   = !fits12;
        end
        3'b010: begin
          enc_instr = {imm_i[12], imm_i[10:5], rs2_i,
                       rs1_i, funct3_i, imm_i[4:1],
                       imm_i[11], opcode_i};
          enc_err   = !fits13 || imm_i[0];
        end
        3'b011: begin
          enc_instr = {imm_i[20], imm_i[10:1], imm_i[11],
                       imm_i[19:12], rd_i, opcode_i};
          enc_err   = !fits21 || imm_i[0];
        end
        3'b100: begin
          enc_instr = {imm_i[31:12], rd_i, opcode_i};
          enc_err   = (imm_i[11:0] != '0);
        end
        default: begin
          enc_instr = '0;
          enc_err   = 1'b1;
        end
      endcase
    end
  end

  assign in_ready_o  = (state == S_IDLE) &&
                       (!out_valid || out_ready_i);
  assign out_valid_o = out_valid;
  assign instr_o     = instr;
  assign err_o       = err;
  assign last_o      = last;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      instr     <= '0;
      err       <= 1'b0;
      last      <= 1'b0;
      pend      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid_i && in_ready_o) begin
            out_valid <= 1'b1;
            instr     <= enc_instr;
            err       <= enc_err;
            last      <= !enc_two;
            pend      <= enc_pend;
            if (enc_two) state <= S_SECOND;
          end else if (out_ready_i) begin
            out_valid <= 1'b0;
          end
        end
        S_SECOND: begin
          // LUI beat is on the output; swap in ADDI once it is taken.
          if (out_ready_i) begin
            instr <= pend;
            err   <= 1'b0;
            last  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_encode.sv
// tb_imm_encode: directed vector table, backpressure and reset sequences,
// then randomized traffic against an arithmetic reference model.
module tb_imm_encode;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        li;
  logic [2:0]  imm_src;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        err;
  logic        last;

  imm_encode #(.DATA_WIDTH(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .li_i       (li),
    .imm_src_i  (imm_src),
    .opcode_i   (opcode),
    .funct3_i   (funct3),
    .rd_i       (rd),
    .rs1_i      (rs1),
    .rs2_i      (rs2),
    .imm_i      (imm),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .instr_o    (instr),
    .err_o      (err),
    .last_o     (last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        li;
    logic [2:0]  src;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic        last;
  } beat_t;

  typedef struct {
    string       name;
    req_t        r;
    int          n;
    logic [31:0] w0;
    logic        e0;
    logic [31:0] w1;
  } vec_t;

  int    total = 0;
  int    bad   = 0;
  beat_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input req_t r, input logic v);
    in_valid = v;
    li       = r.li;
    imm_src  = r.src;
    opcode   = r.op;
    funct3   = r.f3;
    rd       = r.rd;
    rs1      = r.rs1;
    rs2      = r.rs2;
    imm      = r.imm;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  function automatic req_t mk(input logic l, input logic [2:0] s,
                              input logic [6:0] o, input logic [2:0] f,
                              input logic [4:0] d, input logic [4:0] a,
                              input logic [4:0] b, input logic [31:0] i);
    req_t r;
    r.li = l; r.src = s; r.op = o; r.f3 = f;
    r.rd = d; r.rs1 = a; r.rs2 = b; r.imm = i;
    return r;
  endfunction

  // Reference model: range checks as signed integer comparisons, li split
  // computed as hi = (value - signed(lo)) / 4096 modulo 2^20.
  function automatic void predict(input req_t r);
    beat_t  b;
    longint v;
    longint lo;
    longint hi;
    logic   ok;
    logic [19:0] hi20;
    v = longint'($signed(r.imm));
    if (r.li) begin
      lo   = longint'($signed(r.imm[11:0]));
      hi   = ((longint'(r.imm) - lo) >>> 12) & 64'hFFFFF;
      hi20 = hi[19:0];
      b.err = 1'b0;
      if (hi == 0) begin
        b.instr = {r.imm[11:0], 5'd0, 3'd0, r.rd, 7'h13};
        b.last  = 1'b1;
        sb.push_back(b);
      end else if (lo == 0) begin
        b.instr = {hi20, r.rd, 7'h37};
        b.last  = 1'b1;
        sb.push_back(b);
      end else begin
        b.instr = {hi20, r.rd, 7'h37};
        b.last  = 1'b0;
        sb.push_back(b);
        b.instr = {r.imm[11:0], r.rd, 3'd0, r.rd, 7'h13};
        b.last  = 1'b1;
        sb.push_back(b);
      end
      return;
    end
    b.last = 1'b1;
    case (r.src)
      3'd0: begin
        ok = (v >= -2048) && (v <= 2047);
        b.instr = {r.imm[11:0], r.rs1, r.f3, r.rd, r.op};
      end
      3'd1: begin
        ok = (v >= -2048) && (v <= 2047);
        b.instr = {r.imm[11:5], r.rs2, r.rs1, r.f3,
                   r.imm[4:0], r.op};
      end
      3'd2: begin
        ok = (v >= -4096) && (v <= 4095) && (v % 2 == 0);
        b.instr = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.f3,
                   r.imm[4:1], r.imm[11], r.op};
      end
      3'd3: begin
        ok = (v >= -1048576) && (v <= 1048575) && (v % 2 == 0);
        b.instr = {r.imm[20], r.imm[10:1], r.imm[11],
                   r.imm[19:12], r.rd, r.op};
      end
      3'd4: begin
        ok = (r.imm % 4096 == 0);
        b.instr = {r.imm[31:12], r.rd, r.op};
      end
      default: begin
        ok = 1'b0;
        b.instr = '0;
      end
    endcase
    b.err = !ok;
    sb.push_back(b);
  endfunction

  function automatic logic [31:0] rnd_imm();
    case ($urandom % 4)
      0: return $urandom;
      1: return 32'($signed($urandom_range(0, 8191)) - 4096);
      2: return $urandom & 32'hFFFFF000;
      default: return 32'(($signed($urandom_range(0, 2097151))
                           - 1048576)) & 32'hFFFFFFFE;
    endcase
  endfunction

  vec_t vecs[$];

  task automatic run_vec(input vec_t v);
    drive(v.r, 1'b1);
    out_ready = 1'b1;
    #1;
    chk({v.name, " ready"}, 64'(in_ready), 64'd1);
    next_cyc();
    in_valid = 1'b0;
    #1;
    chk({v.name, " beat1"}, {out_valid, instr, err, last},
        {1'b1, v.w0, v.e0, (v.n == 1)});
    if (v.n == 2) begin
      chk({v.name, " busy"}, 64'(in_ready), 64'd0);
      next_cyc();
      chk({v.name, " beat2"}, {out_valid, instr, err, last},
          {1'b1, v.w1, 1'b0, 1'b1});
    end
    next_cyc();
    chk({v.name, " idle"}, 64'(out_valid), 64'd0);
  endtask

  task automatic add(input string nm, input req_t r, input int n,
                     input logic [31:0] w0, input logic e0,
                     input logic [31:0] w1);
    vec_t v;
    v.name = nm; v.r = r; v.n = n; v.w0 = w0; v.e0 = e0; v.w1 = w1;
    vecs.push_back(v);
  endtask

  initial begin
    req_t  r;
    beat_t b;
    logic  stall;
    logic [33:0] held;
    logic  in_fire;
    logic  out_fire;
    logic  exp_rdy;

    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    out_ready = 1'b0;

    add("i_neg5", mk(0, 0, 7'h13, 0, 1, 2, 0, 32'hFFFFFFFB),
        1, 32'hFFB10093, 0, 0);
    add("j_800", mk(0, 3, 7'h6F, 0, 1, 0, 0, 32'h800),
        1, 32'h001000EF, 0, 0);
    add("b_odd", mk(0, 2, 7'h63, 0, 0, 0, 0, 32'd3),
        1, 32'h00000163, 1, 0);
    add("b_4096", mk(0, 2, 7'h63, 0, 0, 0, 0, 32'd4096),
        1, 32'h80000063, 1, 0);
    add("b_8", mk(0, 2, 7'h63, 0, 0, 1, 2, 32'd8),
        1, 32'h00208463, 0, 0);
    add("s_neg4", mk(0, 1, 7'h23, 2, 0, 2, 3, 32'hFFFFFFFC),
        1, 32'hFE312E23, 0, 0);
    add("j_neg4", mk(0, 3, 7'h6F, 0, 0, 0, 0, 32'hFFFFFFFC),
        1, 32'hFFDFF06F, 0, 0);
    add("u_ok", mk(0, 4, 7'h37, 0, 5, 0, 0, 32'h12345000),
        1, 32'h123452B7, 0, 0);
    add("u_low", mk(0, 4, 7'h37, 0, 5, 0, 0, 32'h12345001),
        1, 32'h123452B7, 1, 0);
    add("i_2048", mk(0, 0, 7'h13, 0, 1, 0, 0, 32'h800),
        1, 32'h80000093, 1, 0);
    add("bad_src", mk(0, 5, 7'h13, 1, 1, 1, 1, 32'h0),
        1, 32'h0, 1, 0);
    add("li_pair", mk(1, 7, 0, 0, 5, 0, 0, 32'h12345FFF),
        2, 32'h123462B7, 0, 32'hFFF28293);
    add("li_7ff", mk(1, 0, 0, 0, 5, 0, 0, 32'h7FF),
        1, 32'h7FF00293, 0, 0);
    add("li_lui", mk(1, 0, 0, 0, 5, 0, 0, 32'h12345000),
        1, 32'h123452B7, 0, 0);
    add("li_zero", mk(1, 0, 0, 0, 5, 0, 0, 32'h0),
        1, 32'h00000293, 0, 0);
    add("li_wrap", mk(1, 0, 0, 0, 5, 0, 0, 32'hFFFFF800),
        1, 32'h80000293, 0, 0);

    // Reset state
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset outs", {out_valid, instr, err, last}, 64'd0);
    rst = 1'b0;
    #1;
    chk("reset ready", 64'(in_ready), 64'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure during the LUI beat
    drive(mk(1, 0, 0, 0, 5, 0, 0, 32'h12345FFF), 1'b1);
    out_ready = 1'b1;
    next_cyc();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("bp beat1", {out_valid, instr, last}, {1'b1, 32'h123462B7, 1'b0});
    for (int k = 0; k < 3; k++) begin
      next_cyc();
      chk("bp hold", {out_valid, instr, last, in_ready},
          {1'b1, 32'h123462B7, 1'b0, 1'b0});
    end
    out_ready = 1'b1;
    next_cyc();
    chk("bp beat2", {out_valid, instr, err, last},
        {1'b1, 32'hFFF28293, 1'b0, 1'b1});
    next_cyc();
    chk("bp idle", 64'(out_valid), 64'd0);

    // Asynchronous reset while the ADDI beat is pending
    drive(mk(1, 0, 0, 0, 5, 0, 0, 32'h12345FFF), 1'b1);
    next_cyc();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst beat1", {out_valid, instr}, {1'b1, 32'h123462B7});
    #2;
    rst = 1'b1;
    #1;
    chk("rst async", {out_valid, instr, err, last}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      next_cyc();
      chk("rst no addi", {out_valid, in_ready}, {1'b0, 1'b1});
    end

    // Randomized traffic with random backpressure
    stall = 1'b0;
    held  = '0;
    for (int c = 0; c < 4000; c++) begin
      r.li  = ($urandom % 4 == 0);
      r.src = 3'($urandom % 8);
      r.op  = 7'($urandom);
      r.f3  = 3'($urandom);
      r.rd  = 5'($urandom);
      r.rs1 = 5'($urandom);
      r.rs2 = 5'($urandom);
      r.imm = rnd_imm();
      drive(r, ($urandom % 3 != 0));
      out_ready = ($urandom % 4 != 0);
      #1;
      if (stall)
        chk("rnd hold", {out_valid, instr, err, last}, {1'b1, held});
      exp_rdy = (sb.size() == 0) || (sb.size() == 1 && out_ready);
      chk("rnd ready", 64'(in_ready), 64'(exp_rdy));
      chk("rnd valid", 64'(out_valid), 64'(sb.size() != 0));
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire && sb.size() != 0) begin
        b = sb.pop_front();
        chk("rnd beat", {instr, err, last}, {b.instr, b.err, b.last});
      end
      if (in_fire) predict(r);
      stall = out_valid && !out_ready;
      held  = {instr, err, last};
      next_cyc();
    end

    // Drain with a bounded cycle budget
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 10 && sb.size() != 0; k++) begin
      if (out_valid) begin
        b = sb.pop_front();
        chk("drain beat", {instr, err, last}, {b.instr, b.err, b.last});
      end
      next_cyc();
    end
    chk("drain empty", 64'(sb.size()), 64'd0);
    chk("drain idle", {out_valid, in_ready}, {1'b0, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
